// File: rtl/demux_1_8_deserializer.sv
// demux_1_8_deserializer: reassembles an LSB-first serial stream into 8-bit frames,
// steering each accepted bit into the slot addressed by a 3-bit select counter.
module demux_1_8_deserializer (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       serial_input,
   input  logic       valid_input,
   input  logic       start_input,
   output logic [7:0] data_output,
   output logic       data_valid_output,
   output logic       frame_error_output,
   output logic       busy_output,
   output logic [2:0] select_output
);
   typedef enum logic {IDLE, COLLECT} state_t;
   state_t     state;
   logic [2:0] sel;
   logic [6:0] staging;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state              <= IDLE;
         sel                <= 3'd0;
         staging            <= 7'd0;
         data_output        <= 8'h00;
         data_valid_output  <= 1'b0;
         frame_error_output <= 1'b0;
      end else begin
         data_valid_output  <= 1'b0;
         frame_error_output <= 1'b0;
         if (valid_input) begin
            if (start_input) begin
               // a start while collecting abandons the partial frame
               frame_error_output <= (state == COLLECT);
               staging[0]         <= serial_input;
               sel                <= 3'd1;
               state              <= COLLECT;
            end else if (state == IDLE) begin
               frame_error_output <= 1'b1;
            end else if (sel == 3'd7) begin
               data_output       <= {serial_input, staging};
               data_valid_output <= 1'b1;
               sel               <= 3'd0;
               state             <= IDLE;
            end else begin
               staging[sel] <= serial_input;
               sel          <= sel + 3'd1;
            end
         end
      end
   end
   assign busy_output   = (state == COLLECT);
   assign select_output = sel;
endmodule

// File: tb/tb_demux_1_8_deserializer.sv
// tb_demux_1_8_deserializer: randomized and directed checks against a queue-based frame model.
module tb_demux_1_8_deserializer;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       serial_input = 1'b0;
   logic       valid_input = 1'b0;
   logic       start_input = 1'b0;
   logic [7:0] data_output;
   logic       data_valid_output;
   logic       frame_error_output;
   logic       busy_output;
   logic [2:0] select_output;
   int         passed = 0;
   int         total = 0;

   demux_1_8_deserializer dut (
      .clk(clk),
      .reset_n(reset_n),
      .serial_input(serial_input),
      .valid_input(valid_input),
      .start_input(start_input),
      .data_output(data_output),
      .data_valid_output(data_valid_output),
      .frame_error_output(frame_error_output),
      .busy_output(busy_output),
      .select_output(select_output)
   );

   always #5 clk = ~clk;

   // model: bits of the current partial frame, last completed word, event flags
   bit         q[$];
   logic [7:0] m_data = 8'h00;
   logic       m_valid = 1'b0;
   logic       m_err = 1'b0;

   wire [13:0] obs = {data_output, data_valid_output, frame_error_output, busy_output, select_output};

   function automatic logic [13:0] exp_vec();
      return {m_data, m_valid, m_err, q.size() != 0, 3'(q.size())};
   endfunction

   task automatic model_reset();
      q.delete();
      m_data = 8'h00;
      m_valid = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic drive(input logic v, input logic s, input logic b);
      valid_input = v;
      start_input = s;
      serial_input = b;
      m_valid = 1'b0;
      m_err = 1'b0;
      if (v) begin
         if (s) begin
            m_err = (q.size() != 0);
            q.delete();
            q.push_back(b);
         end else if (q.size() == 0) begin
            m_err = 1'b1;
         end else begin
            q.push_back(b);
            if (q.size() == 8) begin
               for (int i = 0; i < 8; i++) m_data[i] = q[i];
               m_valid = 1'b1;
               q.delete();
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         valid_input = 1'($urandom);
         start_input = 1'($urandom);
         serial_input = 1'($urandom);
         @(posedge clk);
         #1;
         total++;
         if (obs !== 14'd0) $display("FAIL reset_hold got %h want 0000", obs);
         else passed++;
      end
      valid_input = 1'b0;
      start_input = 1'b0;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b0);
         total++;
         if (obs !== 14'd0) $display("FAIL reset_idle got %h want 0000", obs);
         else passed++;
      end
   endtask

   task automatic test_single();
      logic [7:0] w = 8'hA5;
      int busy_cycles = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, i == 0, w[i]);
         total++;
         if (obs !== exp_vec()) $display("FAIL single_bit%0d got %h want %h", i, obs, exp_vec());
         else passed++;
         if (busy_output) busy_cycles++;
      end
      total++;
      if (data_output !== 8'hA5 || data_valid_output !== 1'b1 || select_output !== 3'd0)
         $display("FAIL single_word got %h/%b/%0d want a5/1/0", data_output, data_valid_output, select_output);
      else passed++;
      total++;
      if (busy_cycles != 7) $display("FAIL single_busy got %0d want 7", busy_cycles);
      else passed++;
      drive(1'b0, 1'b0, 1'b0);
      total++;
      if (obs !== exp_vec() || data_valid_output !== 1'b0) $display("FAIL single_after got %h want %h", obs, exp_vec());
      else passed++;
   endtask

   task automatic test_gapped();
      logic [7:0] w = 8'h3C;
      int vcnt = 0;
      int ecnt = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, i == 0, w[i]);
         vcnt += int'(data_valid_output);
         ecnt += int'(frame_error_output);
         total++;
         if (obs !== exp_vec()) $display("FAIL gapped_bit%0d got %h want %h", i, obs, exp_vec());
         else passed++;
         for (int g = 0; g < 2; g++) begin
            drive(1'b0, 1'($urandom), 1'($urandom));
            vcnt += int'(data_valid_output);
            ecnt += int'(frame_error_output);
            total++;
            if (obs !== exp_vec()) $display("FAIL gapped_gap%0d got %h want %h", i, obs, exp_vec());
            else passed++;
         end
      end
      total++;
      if (data_output !== 8'h3C || vcnt != 1 || ecnt != 0)
         $display("FAIL gapped_summary got %h v%0d e%0d want 3c v1 e0", data_output, vcnt, ecnt);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [15:0] w = 16'h01FF;
      int first = -1;
      int second = -1;
      int ecnt = 0;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, (i % 8) == 0, w[i]);
         ecnt += int'(frame_error_output);
         total++;
         if (obs !== exp_vec()) $display("FAIL b2b_bit%0d got %h want %h", i, obs, exp_vec());
         else passed++;
         if (data_valid_output) begin
            if (first < 0) begin
               first = i;
               total++;
               if (data_output !== 8'hFF) $display("FAIL b2b_first got %h want ff", data_output);
               else passed++;
            end else second = i;
         end
      end
      total++;
      if (second - first != 8 || data_output !== 8'h01 || ecnt != 0)
         $display("FAIL b2b_summary got gap %0d data %h e%0d want 8 01 0", second - first, data_output, ecnt);
      else passed++;
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_restart();
      logic [7:0] w = 8'h81;
      logic [7:0] old = data_output;
      int ecnt = 0;
      for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 1'($urandom));
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, i == 0, w[i]);
         ecnt += int'(frame_error_output);
         total++;
         if (obs !== exp_vec()) $display("FAIL restart_bit%0d got %h want %h", i, obs, exp_vec());
         else passed++;
         if (i == 0) begin
            total++;
            if (frame_error_output !== 1'b1 || data_output !== old)
               $display("FAIL restart_edge got e%b %h want e1 %h", frame_error_output, data_output, old);
            else passed++;
         end
      end
      total++;
      if (data_output !== 8'h81 || data_valid_output !== 1'b1 || ecnt != 1)
         $display("FAIL restart_word got %h v%b e%0d want 81 1 1", data_output, data_valid_output, ecnt);
      else passed++;
   endtask

   task automatic test_stray_and_abort();
      drive(1'b1, 1'b0, 1'b1);
      total++;
      if (frame_error_output !== 1'b1 || select_output !== 3'd0 || obs !== exp_vec())
         $display("FAIL stray got %h want %h", obs, exp_vec());
      else passed++;
      for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 1'($urandom));
      total++;
      if (select_output !== 3'd5 || busy_output !== 1'b1) $display("FAIL abort_pre got sel %0d busy %b want 5 1", select_output, busy_output);
      else passed++;
      valid_input = 1'b0;
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (obs !== 14'd0 || obs !== exp_vec()) $display("FAIL abort_async got %h want 0000", obs);
      else passed++;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (obs !== 14'd0) $display("FAIL abort_after got %h want 0000", obs);
      else passed++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0), 1'($urandom));
         total++;
         if (obs !== exp_vec()) $display("FAIL random_c%0d got %h want %h", i, obs, exp_vec());
         else passed++;
         total++;
         if (data_valid_output && frame_error_output) $display("FAIL random_both_c%0d got 1/1 want exclusive", i);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_gapped();
      test_back_to_back();
      test_restart();
      test_stray_and_abort();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
